// File: rtl/frame_geometry.sv
// frame_geometry: forwards a camera pixel stream with one cycle of latency, tags each
// forwarded pixel with its X/Y coordinate, measures line width and frame height, and
// reports when the frame geometry has been stable for LOCK_FRAMES complete frames.
//
// Ports:
//   Clk, nReset            clock (rising edge), asynchronous active-low reset
//   PixelIn/FrameIn/LineIn input pixel stream and its frame/line qualifiers
//   PixelOut/FrameOut/LineOut  inputs delayed by one cycle
//   X, Y                   coordinate of the pixel currently on PixelOut
//   Width                  pixel count of the last completed line (in a frame)
//   Height                 line count of the last completed frame
//   Locked                 geometry identical for LOCK_FRAMES regular frames
//   WidthOvf, HeightOvf    counter saturated in the current or last frame
//   FrameDone              one-cycle pulse when Height/Locked update
module frame_geometry #(
  parameter int unsigned PIX_BITS    = 8,
  parameter int unsigned W_BITS      = 11,
  parameter int unsigned H_BITS      = 11,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic [PIX_BITS-1:0] PixelIn,
  input  logic                FrameIn,
  input  logic                LineIn,
  output logic [PIX_BITS-1:0] PixelOut,
  output logic                FrameOut,
  output logic                LineOut,
  output logic [W_BITS-1:0]   X,
  output logic [H_BITS-1:0]   Y,
  output logic [W_BITS-1:0]   Width,
  output logic [H_BITS-1:0]   Height,
  output logic                Locked,
  output logic                WidthOvf,
  output logic                HeightOvf,
  output logic                FrameDone
);

  localparam logic [0:0]        StIdle   = 1'b0;
  localparam logic [0:0]        StActive = 1'b1;
  localparam logic [W_BITS-1:0] XMax     = {W_BITS{1'b1}};
  localparam logic [H_BITS-1:0] YMax     = {H_BITS{1'b1}};
  localparam logic [3:0]        LockMax  = 4'(LOCK_FRAMES);

  logic [PIX_BITS-1:0] r_pix;
  logic                r_frame;
  logic                r_line;
  logic                r_armed;
  logic [0:0]          r_state;
  logic [W_BITS-1:0]   r_x;
  logic [H_BITS-1:0]   r_y;
  logic                r_first_line;
  logic [W_BITS-1:0]   r_width;
  logic [H_BITS-1:0]   r_height;
  logic                r_wovf;
  logic                r_hovf;
  logic [W_BITS-1:0]   r_first_cnt;
  logic                r_have_first;
  logic                r_irreg;
  logic [W_BITS-1:0]   r_prev_w;
  logic [H_BITS-1:0]   r_prev_h;
  logic                r_prev_valid;
  logic [3:0]          r_lock_cnt;
  logic                r_done;

  logic              w_frame_rise;
  logic              w_frame_fall;
  logic              w_line_rise;
  logic              w_line_fall;
  logic              w_active;
  logic              w_count;
  logic              w_line_start;
  logic              w_first;
  logic [W_BITS-1:0] w_x_inc;
  logic [W_BITS-1:0] w_x_next;
  logic [H_BITS-1:0] w_y_inc;
  logic [H_BITS-1:0] w_y_next;
  logic              w_measure;
  logic              w_end;
  logic [W_BITS-1:0] w_frame_w;
  logic [H_BITS-1:0] w_frame_h;
  logic              w_irreg;
  logic              w_ok;
  logic              w_match;
  logic [3:0]        w_lock_next;

  // Edges are suppressed on the first cycle after reset so that a frame already in
  // progress at reset release (input registers cleared to 0) is not mistaken for a start.
  assign w_frame_rise = r_armed & FrameIn & ~r_frame;
  assign w_frame_fall = r_armed & ~FrameIn & r_frame;
  assign w_line_rise  = r_armed & LineIn & ~r_line;
  assign w_line_fall  = r_armed & ~LineIn & r_line;
  assign w_active     = (r_state == StActive);

  // Pixels are counted inside an accepted frame, including a line starting with the frame.
  assign w_count      = LineIn & ((w_active & FrameIn) | w_frame_rise);
  assign w_line_start = w_count & w_line_rise;
  assign w_first      = w_frame_rise | r_first_line;

  assign w_x_inc  = (r_x == XMax) ? XMax : r_x + 1'b1;
  assign w_x_next = w_line_rise ? '0 : w_x_inc;
  assign w_y_inc  = (r_y == YMax) ? YMax : r_y + 1'b1;
  assign w_y_next = w_first ? '0 : w_y_inc;

  // w_x_inc doubles as the saturated pixel count of the line that just ended.
  assign w_measure = w_line_fall & w_active;
  assign w_end     = w_frame_fall & w_active;
  assign w_frame_w = w_measure ? w_x_inc : r_width;
  assign w_frame_h = r_first_line ? '0 : w_y_inc;

  assign w_irreg = r_irreg | (w_measure & r_have_first & (w_x_inc != r_first_cnt));
  assign w_ok    = ~w_irreg & ~r_wovf & ~r_hovf;
  assign w_match = r_prev_valid & (w_frame_w == r_prev_w) & (w_frame_h == r_prev_h);

  always_comb begin
    w_lock_next = 4'd0;
    if (w_ok && w_match) begin
      w_lock_next = (r_lock_cnt >= LockMax) ? LockMax : r_lock_cnt + 4'd1;
    end else if (w_ok) begin
      w_lock_next = 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_pix        <= '0;
      r_frame      <= 1'b0;
      r_line       <= 1'b0;
      r_armed      <= 1'b0;
      r_state      <= StIdle;
      r_x          <= '0;
      r_y          <= '0;
      r_first_line <= 1'b0;
      r_width      <= '0;
      r_height     <= '0;
      r_wovf       <= 1'b0;
      r_hovf       <= 1'b0;
      r_first_cnt  <= '0;
      r_have_first <= 1'b0;
      r_irreg      <= 1'b0;
      r_prev_w     <= '0;
      r_prev_h     <= '0;
      r_prev_valid <= 1'b0;
      r_lock_cnt   <= 4'd0;
      r_done       <= 1'b0;
    end else begin
      r_pix   <= PixelIn;
      r_frame <= FrameIn;
      r_line  <= LineIn;
      r_armed <= 1'b1;
      r_done  <= w_end;

      case (r_state)
        StIdle:   if (w_frame_rise) r_state <= StActive;
        StActive: if (w_frame_fall) r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase

      if (w_count) r_x <= w_x_next;
      if (w_line_start) r_y <= w_y_next;

      if (w_frame_rise) begin
        r_first_line <= ~w_line_start;
      end else if (w_line_start) begin
        r_first_line <= 1'b0;
      end

      // Flags are cleared on the rise; the previous frame's evaluation happened at its fall.
      r_wovf <= (r_wovf & ~w_frame_rise) | (w_count & (w_x_next == XMax));
      r_hovf <= (r_hovf & ~w_frame_rise) | (w_line_start & (w_y_next == YMax));

      if (w_measure) r_width <= w_x_inc;

      if (w_frame_rise) begin
        r_have_first <= 1'b0;
        r_irreg      <= 1'b0;
      end else if (w_measure) begin
        if (!r_have_first) begin
          r_first_cnt  <= w_x_inc;
          r_have_first <= 1'b1;
        end else if (w_x_inc != r_first_cnt) begin
          r_irreg <= 1'b1;
        end
      end

      if (w_end) begin
        r_height     <= w_frame_h;
        r_prev_w     <= w_frame_w;
        r_prev_h     <= w_frame_h;
        r_prev_valid <= 1'b1;
        r_lock_cnt   <= w_lock_next;
      end
    end
  end

  assign PixelOut  = r_pix;
  assign FrameOut  = r_frame;
  assign LineOut   = r_line;
  assign X         = r_x;
  assign Y         = r_y;
  assign Width     = r_width;
  assign Height    = r_height;
  assign Locked    = (r_lock_cnt == LockMax);
  assign WidthOvf  = r_wovf;
  assign HeightOvf = r_hovf;
  assign FrameDone = r_done;

endmodule

// File: doc/frame_geometry.md
Name: frame_geometry

Overview:
- Parametrised successor to the separate Width/Height measurement blocks in the Hough pipeline front end.
- Forwards the pixel stream unchanged with one-cycle latency and tags each pixel with X/Y coordinates.
- Measures active line width and frame height, flags overflow, and asserts Locked once the geometry has been stable for a set number of frames.
- Sits between the camera input and the Edge/Circle stages; downstream blocks take Width/Height/X/Y from it.

Parameters:
PIX_BITS, 8, pixel data width
W_BITS, 11, width of the X counter and Width result
H_BITS, 11, width of the Y counter and Height result
LOCK_FRAMES, 2, consecutive identical complete frames required to assert Locked (legal range 1..15)

Ports:
Clk  in  1  single system clock, rising edge
nReset  in  1  asynchronous active-low reset
PixelIn  in  PIX_BITS  pixel data, one pixel per clock while LineIn high
FrameIn  in  1  high for the whole frame
LineIn  in  1  high for active pixels of a line
PixelOut  out  PIX_BITS  PixelIn delayed 1 cycle
FrameOut  out  1  FrameIn delayed 1 cycle
LineOut  out  1  LineIn delayed 1 cycle
X  out  W_BITS  column of the pixel on PixelOut
Y  out  H_BITS  row of the pixel on PixelOut
Width  out  W_BITS  pixel count of the last completed line
Height  out  H_BITS  line count of the last completed frame
Locked  out  1  geometry stable
WidthOvf  out  1  a line in the current or last frame exceeded 2^W_BITS-1 pixels
HeightOvf  out  1  the current or last frame exceeded 2^H_BITS-1 lines
FrameDone  out  1  one-cycle pulse when Height/Locked update

Behaviour:
- Reset (async, nReset=0): every output and internal register goes to 0. State becomes IDLE.
- Passthrough: PixelOut, FrameOut and LineOut are registered copies of the inputs, 1 cycle of latency, including outside active periods.
- Edges: detected against the previous-cycle input registers.
- States:
  - IDLE -> ACTIVE on a FrameIn rising edge.
  - ACTIVE -> IDLE on a FrameIn falling edge.
  - A frame already in progress when reset is released has no rising edge, so it is ignored. No Height update and no FrameDone occur until the next rising edge.
- X:
  - 0 on the first LineIn-high cycle of a line; +1 per LineIn-high cycle.
  - Saturates at 2^W_BITS-1 and sets WidthOvf.
  - Output aligned with PixelOut.
  - When LineOut is low, X holds its last value.
- Y:
  - 0 for the first line of the frame; +1 on each LineIn rising edge after the first line of the frame.
  - Saturates at 2^H_BITS-1 and sets HeightOvf.
  - Aligned with PixelOut.
- Width: loaded with the line's pixel count (X+1, saturated) on each LineIn falling edge in ACTIVE. Lines outside ACTIVE are forwarded, but they are not counted or measured.
- Irregular-frame flag: set when any line's count in the frame differs from the first line's count. Cleared at frame start.
- Frame end (FrameIn falling edge in ACTIVE):
  - Height is loaded with the line count. A frame with zero lines gives Height=0.
  - FrameDone pulses on the next cycle.
- Simultaneous events:
  - LineIn and FrameIn rising on the same cycle: the line is line 0.
  - LineIn and FrameIn falling on the same cycle: the line's Width is captured and the line is included in Height.
- Lock counter (0..LOCK_FRAMES, saturating), evaluated at frame end:
  - The counter increments when the frame is regular, has no overflow, and its (Width, Height) equals the previous complete frame's. The first frame after reset counts as 1.
  - Otherwise the counter reloads to 1 if the frame is regular with no overflow, else to 0.
  - Locked = (count == LOCK_FRAMES). It updates in the same cycle as FrameDone.
- WidthOvf/HeightOvf: sticky within a frame. Cleared on a FrameIn rising edge, after the frame-end evaluation has used them.
- Width/Height change only at their capture points and are otherwise stable.

Test Plan:
- Reset, then 3 frames of 4 lines x 6 pixels (LOCK_FRAMES=2):
  - Width=6 and Height=4 after frame 1.
  - Locked=0 after frame 1; Locked=1 at the FrameDone of frame 2 and stays 1 after frame 3.
  - X runs 0..5 and Y runs 0..3 aligned with PixelOut; PixelOut equals PixelIn delayed 1 cycle.
- Locked 4x6 stream, then a frame whose line 2 has 5 pixels:
  - At that frame's FrameDone: Locked=0, Width=6 (last line).
  - Next regular 4x6 frame: count=1, Locked=0; following frame: Locked=1.
- W_BITS=3, one line of 10 pixels: X saturates at 7, Width=7, WidthOvf=1, Locked stays 0. WidthOvf clears on the next FrameIn rise.
- LineIn and FrameIn rising together and falling together on a 2x3 frame: Height=2, Width=3, Y=0 on the first pixel.
- Assert nReset mid-line of frame 2 and release with FrameIn still high:
  - All outputs 0 during reset.
  - The remainder of the frame produces no FrameDone.
  - The next full frame gives a correct Height and lock count=1.
